// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RISC-V pipeline: resolves load-use, data-bus
// wait states (with timeout) and taken-branch flushes, and counts stalled cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ld_exe_i,
  input  logic [4:0]  ld_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic        jump_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [9:0] WAIT_LAST  = 10'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic       lu;
  logic       to;
  logic       ms;
  logic [5:0] stall;
  logic       flush;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    wait_cnt_d = 10'd0;
    bus_err_d  = 1'b0;
    stall      = STALL_NONE;
    flush      = 1'b0;

    lu = ld_exe_i && (ld_rd_i != 5'd0) &&
         ((id_rs1_re_i && (id_rs1_i == ld_rd_i)) ||
          (id_rs2_re_i && (id_rs2_i == ld_rd_i)));
    to = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
    ms = mem_req_i && !mem_ack_i && !to;

    unique case (state_q)
      RUN, LU_BUBBLE: begin
        if (ms) begin
          stall      = STALL_MEM;
          state_d    = MEM_WAIT;
          wait_cnt_d = 10'd1;
        end else if (jump_i) begin
          // The ID instruction is wrong-path, so a pending load-use is moot.
          flush   = 1'b1;
          state_d = RUN;
        end else if (lu && (state_q == RUN)) begin
          stall   = STALL_LU;
          state_d = LU_BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (ms) begin
          stall      = STALL_MEM;
          wait_cnt_d = wait_cnt_q + 10'd1;
        end else begin
          // Release on ack, timeout or dropped request; a held jump fires now.
          state_d   = RUN;
          flush     = jump_i;
          bus_err_d = mem_req_i && !mem_ack_i;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q + 32'(stall != STALL_NONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their pre-edge values together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wait_cnt_q  <= 10'd0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign flush_o     = flush;
  assign bus_err_o   = bus_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, reset-mid-wait
// sequence, then randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst_ni;
  logic        ld_exe_i;
  logic [4:0]  ld_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_re_i;
  logic        id_rs2_re_i;
  logic        jump_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        bus_err_o;
  logic [31:0] stall_cnt_o;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ld_exe_i    (ld_exe_i),
    .ld_rd_i     (ld_rd_i),
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .id_rs1_re_i (id_rs1_re_i),
    .id_rs2_re_i (id_rs2_re_i),
    .jump_i      (jump_i),
    .mem_req_i   (mem_req_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .bus_err_o   (bus_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       re1;
    logic       re2;
    logic       jmp;
    logic       req;
    logic       ack;
    logic [5:0] st;
    logic       fl;
    logic       er;
    int         cnt;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input int rd, input int rs1, input int rs2,
                     input logic re1, input logic re2, input logic jmp, input logic req,
                     input logic ack, input logic [5:0] st, input logic fl, input logic er,
                     input int cnt);
    vec_t v;
    v.ld = ld; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.re1 = re1; v.re2 = re2; v.jmp = jmp; v.req = req; v.ack = ack;
    v.st = st; v.fl = fl; v.er = er; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    ld_exe_i = v.ld; ld_rd_i = v.rd; id_rs1_i = v.rs1; id_rs2_i = v.rs2;
    id_rs1_re_i = v.re1; id_rs2_re_i = v.re2; jump_i = v.jmp;
    mem_req_i = v.req; mem_ack_i = v.ack;
  endtask

  task automatic idle_inputs();
    ld_exe_i = 0; ld_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; jump_i = 0; mem_req_i = 0; mem_ack_i = 0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks how long the current bus access has waited and whether
  // the previous cycle inserted a load-use bubble.
  int          m_waited;
  bit          m_masked;
  bit          m_err;
  logic [31:0] m_cnt;

  task automatic model_eval(output logic [5:0] st, output logic fl, output int n_waited,
                            output bit n_masked, output bit n_err);
    bit pending, lu;
    pending  = mem_req_i && !mem_ack_i;
    lu       = ld_exe_i && (ld_rd_i != 0) &&
               ((id_rs1_re_i && id_rs1_i == ld_rd_i) || (id_rs2_re_i && id_rs2_i == ld_rd_i));
    st = 6'b000000; fl = 0; n_waited = 0; n_masked = 0; n_err = 0;
    if (m_waited > 0) begin
      if (pending && m_waited < int'(TIMEOUT) - 1) begin
        st = 6'b011111;
        n_waited = m_waited + 1;
      end else begin
        fl    = jump_i;
        n_err = pending;
      end
    end else if (pending) begin
      st = 6'b011111;
      n_waited = 1;
    end else if (jump_i) begin
      fl = 1;
    end else if (lu && !m_masked) begin
      st = 6'b000111;
      n_masked = 1;
    end
  endtask

  initial begin
    logic [5:0] e_st;
    logic       e_fl;
    int         n_waited;
    bit         n_masked, n_err;
    bit         prev_req;

    // ld rd rs1 rs2 re1 re2 jmp req ack | stall flush err cnt
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,0);
    add(1,5,5,0,1,0, 0,0,0, 6'h07,0,0,0);   // load-use bubble
    add(1,5,5,0,1,0, 0,0,0, 6'h00,0,0,1);   // re-detection masked
    add(1,0,0,0,1,0, 0,0,0, 6'h00,0,0,1);   // x0 never hazards
    add(1,7,0,7,0,1, 0,0,0, 6'h07,0,0,1);   // via rs2
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,2);
    add(1,7,0,7,0,0, 0,0,0, 6'h00,0,0,2);   // rs2 not read
    add(1,3,3,0,1,0, 1,0,0, 6'h00,1,0,2);   // jump overrides load-use
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,2);   // 3-cycle wait
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,3);
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,4);
    add(0,0,0,0,0,0, 0,1,1, 6'h00,0,0,5);
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,5);
    add(0,0,0,0,0,0, 1,1,0, 6'h1F,0,0,5);   // deferred flush
    add(0,0,0,0,0,0, 1,1,0, 6'h1F,0,0,6);
    add(0,0,0,0,0,0, 1,1,1, 6'h00,1,0,7);
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,7);   // timeout
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,8);
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,9);
    add(0,0,0,0,0,0, 0,1,0, 6'h00,0,0,10);
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,1,10);
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,10);
    add(0,0,0,0,0,0, 0,1,1, 6'h00,0,0,10);  // acked in first cycle
    add(0,0,0,0,0,0, 0,1,0, 6'h1F,0,0,10);  // request dropped
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,11);
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,11);
    add(1,5,5,0,1,0, 0,0,0, 6'h07,0,0,11);  // memory stall in bubble
    add(1,5,5,0,1,0, 0,1,0, 6'h1F,0,0,12);
    add(0,0,0,0,0,0, 0,1,1, 6'h00,0,0,13);
    add(1,5,5,0,1,0, 0,0,0, 6'h07,0,0,13);  // back-to-back load-use
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,14);
    add(1,9,0,9,0,1, 0,0,0, 6'h07,0,0,14);
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,15);
    add(1,5,5,0,1,0, 0,0,0, 6'h07,0,0,15);  // jump in bubble
    add(1,5,5,0,1,0, 1,0,0, 6'h00,1,0,16);
    add(0,0,0,0,0,0, 0,0,0, 6'h00,0,0,16);

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vq[i].st));
      check($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(vq[i].fl));
      check($sformatf("vec%0d_buserr", i), 32'(bus_err_o), 32'(vq[i].er));
      check($sformatf("vec%0d_cnt", i), stall_cnt_o, 32'(vq[i].cnt));
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a memory wait.
    do_reset();
    idle_inputs();
    mem_req_i = 1;
    @(negedge clk);
    check("rst_pre_stall0", 32'(stall_o), 32'h1F);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_stall1", 32'(stall_o), 32'h1F);
    check("rst_pre_cnt", stall_cnt_o, 32'd1);
    #2;
    rst_ni    = 1'b0;
    mem_req_i = 0;
    #1;
    check("rst_async_stall", 32'(stall_o), 32'h0);
    check("rst_async_flush", 32'(flush_o), 32'h0);
    check("rst_async_cnt", stall_cnt_o, 32'd0);
    check("rst_async_buserr", 32'(bus_err_o), 32'h0);
    @(posedge clk); #1;
    check("rst_hold_cnt", stall_cnt_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("rst_after_buserr", 32'(bus_err_o), 32'h0);
    ld_exe_i = 1; ld_rd_i = 5; id_rs1_i = 5; id_rs1_re_i = 1;
    @(negedge clk);
    check("rst_after_state_run", 32'(stall_o), 32'h07);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    m_waited = 0; m_masked = 0; m_err = 0; m_cnt = 0;
    prev_req = 0;
    for (int c = 0; c < 3000; c++) begin
      ld_exe_i    = 1'($urandom_range(0, 1));
      ld_rd_i     = 5'($urandom_range(0, 3));
      id_rs1_i    = 5'($urandom_range(0, 3));
      id_rs2_i    = 5'($urandom_range(0, 3));
      id_rs1_re_i = 1'($urandom_range(0, 1));
      id_rs2_re_i = 1'($urandom_range(0, 1));
      jump_i      = ($urandom_range(0, 4) == 0);
      mem_req_i   = prev_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      mem_ack_i   = ($urandom_range(0, 3) == 0);
      prev_req    = mem_req_i && !mem_ack_i;
      @(negedge clk);
      model_eval(e_st, e_fl, n_waited, n_masked, n_err);
      check("rnd_stall", 32'(stall_o), 32'(e_st));
      check("rnd_flush", 32'(flush_o), 32'(e_fl));
      check("rnd_buserr", 32'(bus_err_o), 32'(m_err));
      check("rnd_cnt", stall_cnt_o, m_cnt);
      check("rnd_flush_vs_stall", 32'(flush_o && stall_o[3]), 32'h0);
      @(posedge clk);
      #1;
      m_cnt    = m_cnt + 32'(e_st != 6'd0);
      m_waited = n_waited;
      m_masked = n_masked;
      m_err    = n_err;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the 6-bit `stall` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards:
- load-use hazards, using the load flag and rd published by ID/EX;
- data-bus wait states, with a timeout;
- taken-branch/jump flushes.

It also keeps a stall-cycle performance counter.

## Interface
- `TIMEOUT`, default 255: maximum data-bus wait cycles before the access is abandoned (range 2..1023).
- `clk_i` in 1: pipeline clock; all state updates on its rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `ld_exe_i` in 1: instruction currently in EX is a load (ID/EX `inst_is_load`).
- `ld_rd_i` in 5: destination register of that instruction (ID/EX `rd`).
- `id_rs1_i` in 5: rs1 index of the instruction in ID.
- `id_rs2_i` in 5: rs2 index of the instruction in ID.
- `id_rs1_re_i` in 1: ID instruction reads rs1.
- `id_rs2_re_i` in 1: ID instruction reads rs2.
- `jump_i` in 1: EX resolved a taken branch/jump. It is held stable while EX is stalled.
- `mem_req_i` in 1: MEM stage is presenting a data-bus access this cycle.
- `mem_ack_i` in 1: data bus completes the access this cycle.
- `stall_o` out 6: bit i = 1 (`STOP`) means stage register i holds. Bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- `flush_o` out 1: IF/ID and ID/EX load NOP this edge; PC loads the jump target.
- `bus_err_o` out 1: one-cycle registered pulse when a data access times out.
- `stall_cnt_o` out 32: count of cycles with any `stall_o` bit set; wraps modulo 2^32.

## Operation

**Hazard conditions**
- Load-use: `lu = ld_exe_i & (ld_rd_i != 0) & ((id_rs1_re_i & id_rs1_i == ld_rd_i) | (id_rs2_re_i & id_rs2_i == ld_rd_i))`.
- Memory stall: `ms = mem_req_i & ~mem_ack_i & ~to`, where `to` means `wait_cnt == TIMEOUT-1` in state MEM_WAIT.

**FSM states:** RUN, LU_BUBBLE, MEM_WAIT. All state is 2-bit plus a 10-bit `wait_cnt`.

**RUN**
- If `ms`: `stall_o = 6'b011111`. Next state MEM_WAIT, `wait_cnt <= 1`.
- Else if `jump_i`: `flush_o = 1`, `stall_o = 0`. Stay in RUN. The jump overrides `lu` because the ID instruction is wrong-path.
- Else if `lu`: `stall_o = 6'b000111`, so PC/IF/ID hold and the ID/EX output becomes a bubble. Next state LU_BUBBLE.
- Else: `stall_o = 0`.

**LU_BUBBLE**
- Lasts exactly one cycle and re-detection of `lu` is masked.
- `ms` and `jump_i` are handled as in RUN, including the MEM_WAIT transition.
- Otherwise `stall_o = 0`. Next state RUN.

**MEM_WAIT**
- While `ms`: `stall_o = 6'b011111` and `wait_cnt` increments.
- On `mem_ack_i`: `stall_o = 0` and the state goes to RUN. If `jump_i` is high in the same cycle, `flush_o = 1`.
- On `to` without ack: `stall_o = 0`, the state goes to RUN, and `bus_err_o <= 1` for the next cycle.
- If `mem_req_i` drops without ack, the controller treats it as completion: release and go to RUN.

**Priority:** memory stall > jump flush > load-use. `flush_o` is never high in a cycle where `stall_o[3]` is high; the flush is deferred until release.

**Counter:** `stall_cnt_o` increments on every edge where `stall_o != 0`.

## Timing
- `stall_o` and `flush_o` are combinational from state and inputs (Mealy), valid in the same cycle as the hazard.
- `bus_err_o`, `stall_cnt_o`, state and `wait_cnt` are registered.
- Reset (`rst_ni` low, asynchronous) forces: state RUN, `wait_cnt = 0`, `stall_cnt_o = 0`, `bus_err_o = 0`. With state at RUN, `stall_o = 0` and `flush_o = 0` unless inputs demand otherwise.
- Reset asserted mid-MEM_WAIT abandons the wait immediately, with no `bus_err_o`.
- Load-use costs exactly 1 bubble cycle.
- A memory access acked in its first cycle costs 0 stall cycles. An access acked after N wait cycles costs N stall cycles.
- A timeout costs `TIMEOUT-1` stall cycles. `bus_err_o` rises on the edge after the release cycle.
- Back-to-back load-use events with independent loads produce one bubble each. RUN → LU_BUBBLE → RUN → LU_BUBBLE is legal.

## Test plan
- **Load-use:** in RUN, set `ld_exe_i=1`, `ld_rd_i=5`, `id_rs1_i=5`, `id_rs1_re_i=1`.
  - Required: `stall_o=6'b000111` for exactly 1 cycle, then 0; `stall_cnt_o` +1.
  - Repeat with `ld_rd_i=0`: required `stall_o=0`.
- **Jump vs load-use:** `lu` true and `jump_i=1` in the same cycle.
  - Required: `flush_o=1`, `stall_o=0`, state remains RUN.
- **Memory wait:** `mem_req_i=1` with `mem_ack_i` low for 3 cycles, then high.
  - Required: `stall_o=6'b011111` for 3 cycles, then 0 on the ack cycle; `stall_cnt_o=3`; `bus_err_o` stays 0.
- **Deferred flush:** `jump_i=1` held throughout a 2-cycle memory wait.
  - Required: `flush_o=0` during the wait and `flush_o=1` on the ack cycle only.
- **Timeout:** with `TIMEOUT=4`, `mem_req_i=1` and no ack.
  - Required: 3 stall cycles, release, then `bus_err_o=1` for one cycle.
- **Reset mid-wait:** drop `rst_ni` during MEM_WAIT.
  - Required: asynchronously `stall_o=0`, `stall_cnt_o=0`, `bus_err_o=0`, state RUN.
